// File: rtl/sort_seq_ctrl_if.sv
// RAM-side bus of the sort sequencing controller: one address/write port
// with a synchronous (1-cycle) read data return.
interface sort_seq_ctrl_if #(
  parameter int N = 8,
  parameter int K = 8
) ();
  localparam int AW = $clog2(K);

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [N-1:0]  ram_wdata;
  logic [N-1:0]  ram_rdata;

  modport master (output ram_addr, ram_we, ram_wdata, input  ram_rdata);
  modport slave  (input  ram_addr, ram_we, ram_wdata, output ram_rdata);
endinterface

// File: rtl/sort_seq_ctrl.sv
// Bubble-sort sequencer for a K-entry single-port RAM, sharing the RAM with an
// external load/readback port. Optional macro EARLY_EXIT_EN: stop after a clean pass.
module sort_seq_ctrl #(
  parameter int N = 8,
  parameter int K = 8,
  localparam int AW = $clog2(K)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s,
  input  logic            wrinit,
  input  logic            rd,
  input  logic [AW-1:0]   radd,
  input  logic [N-1:0]    din,
  sort_seq_ctrl_if.master ram,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    dout
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, CMP, WR_LO, WR_HI, PASS, DONE
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  a_q, a_n, b_q, b_n;
  logic [AW-1:0] j, j_n, last, last_n;
  logic          swapped, swapped_n;
  logic          rd_q, rd_n;

  logic [AW-1:0] addr;
  logic          we;
  logic [N-1:0]  wdata;
  logic          pass_end;
  logic          finish_pass;

  assign pass_end = (j == last - AW'(1));

  `ifdef EARLY_EXIT_EN
  assign finish_pass = (last == AW'(1)) || !swapped;
  `else
  assign finish_pass = (last == AW'(1));
  `endif

  always_comb begin
    state_n   = state;
    a_n       = a_q;
    b_n       = b_q;
    j_n       = j;
    last_n    = last;
    swapped_n = swapped;
    rd_n      = 1'b0;
    addr      = '0;
    we        = 1'b0;
    wdata     = '0;

    // External port owns the RAM only while the engine is parked.
    if (state == IDLE || state == DONE) begin
      if (wrinit) begin
        we    = 1'b1;
        addr  = radd;
        wdata = din;
      end else if (rd) begin
        addr = radd;
        rd_n = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (s) begin
          state_n   = RD_A;
          j_n       = '0;
          last_n    = AW'(K - 1);
          swapped_n = 1'b0;
        end
      end
      RD_A: begin
        addr    = j;
        state_n = RD_B;
      end
      RD_B: begin
        addr    = j + AW'(1);
        a_n     = ram.ram_rdata;
        state_n = CMP;
      end
      CMP: begin
        // B is still in flight, so compare against the returning read data.
        b_n = ram.ram_rdata;
        if (a_q > ram.ram_rdata) begin
          state_n = WR_LO;
        end else if (pass_end) begin
          state_n = PASS;
        end else begin
          j_n     = j + AW'(1);
          state_n = RD_A;
        end
      end
      WR_LO: begin
        we      = 1'b1;
        addr    = j;
        wdata   = b_q;
        state_n = WR_HI;
      end
      WR_HI: begin
        we        = 1'b1;
        addr      = j + AW'(1);
        wdata     = a_q;
        swapped_n = 1'b1;
        if (pass_end) begin
          state_n = PASS;
        end else begin
          j_n     = j + AW'(1);
          state_n = RD_A;
        end
      end
      PASS: begin
        last_n    = last - AW'(1);
        j_n       = '0;
        swapped_n = 1'b0;
        state_n   = finish_pass ? DONE : RD_A;
      end
      DONE: begin
        if (!s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      j       <= '0;
      last    <= '0;
      swapped <= 1'b0;
      rd_q    <= 1'b0;
      dout    <= '0;
    end else begin
      state   <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      j       <= j_n;
      last    <= last_n;
      swapped <= swapped_n;
      rd_q    <= rd_n;
      if (rd_q) dout <= ram.ram_rdata;
    end
  end

  assign ram.ram_addr  = addr;
  assign ram.ram_we    = we;
  assign ram.ram_wdata = wdata;
  assign busy = (state == RD_A) || (state == RD_B) || (state == CMP) ||
                (state == WR_LO) || (state == WR_HI) || (state == PASS);
  assign done = (state == DONE);

endmodule
